// File: rtl/rr_bus_arbiter.sv
// Four-requester round-robin bus arbiter.
// Ownership is held until the owner drops its request. When another requester
// is waiting, ownership is also limited to MAX_HOLD consecutive cycles. Every
// change of owner is separated by one idle turnaround cycle. The registered
// owner index and valid flag are decoded into a one-hot grant.
module rr_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [3:0] req,
  output logic [1:0] grantAddr,
  output logic       grantValid,
  output logic [3:0] grant,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  // The hold limit is only enforced when MAX_HOLD is nonzero.
  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic [1:0]       last_owner;
  logic [1:0]       last_owner_next;
  logic [1:0]       addr_next;
  logic             valid_next;
  logic             preempt_next;
  logic [2:0]       winner;
  logic             others_waiting;

  // Decode the owner index into a one-hot grant vector, gated by the valid flag.
  function automatic logic [3:0] decode_grant(input logic [1:0] addr, input logic valid);
    logic [3:0] onehot;
    onehot = 4'b0000;
    if (valid) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = 4'b0000;
    end
    return onehot;
  endfunction

  // Round-robin search. Requesters are checked starting at last+1 and wrapping
  // around to last itself. The return value is {found, index}. The loop visits
  // the farthest candidate first, so the nearest requester overwrites the
  // result and wins.
  function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        result = {1'b1, idx};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Form the one-hot grant from the registered owner state only.
  always_comb begin
    grant = decode_grant(grantAddr, grantValid);
  end

  // Arbitration candidates, and whether anyone other than the owner is waiting.
  always_comb begin
    winner         = pick_winner(req, last_owner);
    others_waiting = |(req & ~grant);
  end

  // Compute the next state and the next values of all registered outputs.
  always_comb begin
    state_next      = state;
    hold_cnt_next   = hold_cnt;
    last_owner_next = last_owner;
    addr_next       = grantAddr;
    valid_next      = grantValid;
    preempt_next    = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (winner[2]) begin
          addr_next     = winner[1:0];
          valid_next    = 1'b1;
          hold_cnt_next = '0;
          state_next    = GRANT;
        end else begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (!req[grantAddr]) begin
          // A release takes priority over a forced rotation on the same edge.
          valid_next      = 1'b0;
          last_owner_next = grantAddr;
          state_next      = GAP;
        end else if (HOLD_EN && (hold_cnt == HOLD_LAST) && others_waiting) begin
          valid_next      = 1'b0;
          last_owner_next = grantAddr;
          preempt_next    = 1'b1;
          state_next      = GAP;
        end else begin
          // The counter saturates so that a late waiter causes rotation on the next edge.
          if (HOLD_EN && (hold_cnt < HOLD_LAST)) begin
            hold_cnt_next = hold_cnt + CNT_W'(1);
          end else begin
            hold_cnt_next = hold_cnt;
          end
          state_next = GRANT;
        end
      end
      default: begin
        // Recover from an illegal state encoding.
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. After reset, requester 0 has top priority.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      grantAddr  <= 2'd0;
      grantValid <= 1'b0;
      preempt    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 2'd3;
    end else begin
      state      <= state_next;
      grantAddr  <= addr_next;
      grantValid <= valid_next;
      preempt    <= preempt_next;
      hold_cnt   <= hold_cnt_next;
      last_owner <= last_owner_next;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter. A behavioural model tracks the
// owner, the last owner and the number of cycles granted, and the DUT outputs
// are compared against it after every clock edge.
module tb_rr_bus_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       nReset;
  logic [3:0] req;
  logic [1:0] grantAddr;
  logic       grantValid;
  logic [3:0] grant;
  logic       preempt;

  int vectors;
  int miscompares;

  // Model state: m_owner is -1 when nobody owns the bus.
  int m_owner;
  int m_last;
  int m_held;
  int m_addr;
  bit m_pre;

  rr_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .req       (req),
    .grantAddr (grantAddr),
    .grantValid(grantValid),
    .grant     (grant),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [7:0] obs = {grant, grantAddr, grantValid, preempt};

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, 2'(m_addr), (m_owner >= 0), m_pre};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_addr  = 0;
    m_pre   = 1'b0;
  endtask

  // One clock edge of the arbitration rules, applied to the sampled requests.
  task automatic model_edge(input logic [3:0] r);
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_pre   = 1'b0;
      end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD &&
                   (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_last  = m_owner;
        m_owner = -1;
        m_pre   = 1'b1;
      end else begin
        m_held++;
        m_pre = 1'b0;
      end
    end else begin
      m_pre = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && r[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_held  = 1;
          m_addr  = m_owner;
        end
      end
    end
  endtask

  task automatic tick(input logic [3:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req    = 4'b0000;
    nReset = 1'b0;
    #1;
    nReset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    nReset = 1'b1;
    req    = 4'b1111;
    #2;
    nReset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: got %b expected %b", obs, 8'h00);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_held: got %b expected %b", obs, 8'h00);
    end
    @(negedge clk);
    nReset = 1'b1;
    tick(4'b1111);
    vectors++;
    if (grant !== 4'b0001 || grantAddr !== 2'd0 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b expected grant 0001 (%b)", obs, exp_vec());
    end
  endtask

  task automatic test_single();
    logic [3:0] stim [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] want [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(stim[i]);
      vectors++;
      if (grant !== want[i] || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL single[%0d]: got %b expected grant %b (%b)", i, obs, want[i], exp_vec());
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] r;
    logic [3:0] seen [$];
    logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       prev_valid;
    do_reset();
    prev_valid = 1'b0;
    for (int i = 0; i < 30 && seen.size() < 5; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      tick(r);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr_cycle[%0d]: got %b expected %b", i, obs, exp_vec());
      end
      if (grantValid && !prev_valid) seen.push_back(grant);
      prev_valid = grantValid;
    end
    vectors++;
    if (seen.size() != 5) begin
      miscompares++;
      $display("FAIL rr_count: got %0d grants expected 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (seen[i] !== want[i]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got %b expected %b", i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_preempt();
    int own0_cycles;
    int pre_count;
    logic [3:0] r;
    do_reset();
    own0_cycles = 0;
    pre_count   = 0;
    for (int i = 0; i < 16; i++) begin
      r = (i < 2) ? 4'b0001 : (i < 13) ? 4'b0101 : 4'b0001;
      tick(r);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL preempt_cycle[%0d]: got %b expected %b", i, obs, exp_vec());
      end
      if (pre_count == 0 && grant == 4'b0001) own0_cycles++;
      if (preempt) pre_count++;
    end
    vectors++;
    if (own0_cycles != 8) begin
      miscompares++;
      $display("FAIL preempt_hold_len: got %0d expected 8", own0_cycles);
    end
    vectors++;
    if (pre_count != 1) begin
      miscompares++;
      $display("FAIL preempt_pulses: got %0d expected 1", pre_count);
    end
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL preempt_regrant: got %b expected 0001", grant);
    end
  endtask

  task automatic test_no_waiter();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(4'b0010);
      vectors++;
      if (grant !== 4'b0010 || preempt !== 1'b0 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL no_waiter[%0d]: got %b expected grant 0010 preempt 0", i, obs);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(4'b1000);
    tick(4'b1000);
    vectors++;
    if (grant !== 4'b1000 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_pre: got %b expected grant 1000", obs);
    end
    @(negedge clk);
    #1;
    nReset = 1'b0;
    req    = 4'b1010;
    #1;
    model_reset();
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL async_drop: got %b expected %b", obs, 8'h00);
    end
    #1;
    nReset = 1'b1;
    @(posedge clk);
    model_edge(4'b1010);
    #1;
    vectors++;
    if (grant !== 4'b0010 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_regrant: got %b expected grant 0010", obs);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
      end
      tick(r);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d] req=%b: got %b expected %b", i, r, obs, exp_vec());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_no_waiter();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
